// File: rtl/d_ff_with_priority_pkg.sv
// Shared types for the prioritised D flip-flop.
// Source selector enum and its priority-ordered pick function.
package d_ff_with_priority_pkg;

  typedef enum logic [1:0] {
    SRC_CLR,
    SRC_PRE,
    SRC_LOAD,
    SRC_DATA
  } src_e;

  // clr beats pre, pre beats load, load beats data.
  // pre is active-low.
  function automatic src_e pick_src(
    input logic clr,
    input logic pre,
    input logic load
  );
    src_e s;
    if (clr)
      s = SRC_CLR;
    else if (!pre)
      s = SRC_PRE;
    else if (load)
      s = SRC_LOAD;
    else
      s = SRC_DATA;
    return s;
  endfunction

endpackage

// File: rtl/d_ff_with_priority.sv
// D flip-flop with synchronous clear, preset (active-low) and alt load.
// Ports: clk, clr, pre, Din, load, loadsignal -> Dout (WIDTH bits).
module d_ff_with_priority
  import d_ff_with_priority_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0,
  parameter logic [WIDTH-1:0] PRE_VAL = '1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pre,
  input  logic [WIDTH-1:0] Din,
  input  logic             load,
  input  logic [WIDTH-1:0] loadsignal,
  output logic [WIDTH-1:0] Dout
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("d_ff_with_priority: WIDTH must be >= 1");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] next_state(
    input src_e             src,
    input logic [WIDTH-1:0] ld,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] n;
    n = d;
    unique case (1'b1)
      (src == SRC_CLR):  n = CLR_VAL;
      (src == SRC_PRE):  n = PRE_VAL;
      (src == SRC_LOAD): n = ld;
      (src == SRC_DATA): n = d;
      default:           n = d;
    endcase
    return n;
  endfunction

  src_e             src;
  logic [WIDTH-1:0] d_nxt;

  always_comb begin
    src   = pick_src(clr, pre, load);
    d_nxt = next_state(src, loadsignal, Din);
  end

  // No hold state: every edge captures something.
  always_ff @(posedge clk) begin
    if (clr)
      Dout <= CLR_VAL;
    else
      Dout <= d_nxt;
  end

endmodule

// File: tb/tb_d_ff_with_priority.sv
// Self-checking bench for d_ff_with_priority.
// Drives a 1-bit and an 8-bit instance from shared controls.
module tb_d_ff_with_priority;

  logic       clk = 1'b0;
  logic       clr, pre, load;
  logic       ls1, din1, q1;
  logic [7:0] ls8, din8, q8;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  d_ff_with_priority u_w1 (
    .clk(clk), .clr(clr), .pre(pre),
    .Din(din1), .load(load),
    .loadsignal(ls1), .Dout(q1)
  );

  d_ff_with_priority #(
    .WIDTH(8), .CLR_VAL(8'h00), .PRE_VAL(8'hA5)
  ) u_w8 (
    .clk(clk), .clr(clr), .pre(pre),
    .Din(din8), .load(load),
    .loadsignal(ls8), .Dout(q8)
  );

  // Reference: first matching rule in the documented priority list.
  function automatic logic [7:0] model(
    input logic c, input logic p, input logic l,
    input logic [7:0] ld, input logic [7:0] d,
    input logic [7:0] cv, input logic [7:0] pv
  );
    if (c) return cv;
    if (p == 1'b0) return pv;
    if (l) return ld;
    return d;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic c, input logic p,
                      input logic l, input logic l1,
                      input logic d1, input logic [7:0] l8,
                      input logic [7:0] d8);
    logic [7:0] e1, e8;
    @(negedge clk);
    clr = c; pre = p; load = l;
    ls1 = l1; din1 = d1; ls8 = l8; din8 = d8;
    e1 = model(c, p, l, {7'b0, l1}, {7'b0, d1}, 8'h00, 8'h01);
    e8 = model(c, p, l, l8, d8, 8'h00, 8'hA5);
    @(posedge clk);
    #1;
    chk({tag, "_w1"}, {7'b0, q1}, e1);
    chk({tag, "_w8"}, q8, e8);
  endtask

  initial begin
    clr = 1'b1; pre = 1'b1; load = 1'b0;
    ls1 = 1'b0; din1 = 1'b0; ls8 = 8'h00; din8 = 8'h00;

    step("reset", 1, 1, 0, 0, 0, 8'h3C, 8'hC3);

    step("pre_a", 0, 0, 1, 0, 0, 8'h3C, 8'hC3);
    step("pre_b", 0, 0, 1, 0, 0, 8'h3C, 8'hC3);

    step("load0", 0, 1, 1, 0, 1, 8'h3C, 8'hC3);
    step("load1", 0, 1, 1, 1, 0, 8'h5A, 8'hC3);
    step("load2", 0, 1, 1, 0, 1, 8'h3C, 8'hC3);

    step("data1", 0, 1, 0, 0, 1, 8'h11, 8'hC3);
    step("data0", 0, 1, 0, 1, 0, 8'h22, 8'h3C);
    step("data2", 0, 1, 0, 0, 1, 8'h33, 8'hC3);

    step("clr_a", 1, 0, 1, 1, 1, 8'h3C, 8'hC3);
    step("clr_b", 1, 0, 1, 1, 1, 8'h3C, 8'hC3);
    step("clr_c", 1, 0, 1, 1, 1, 8'h3C, 8'hC3);
    step("clr_rel", 0, 1, 0, 0, 1, 8'h3C, 8'hC3);

    step("idle0", 0, 1, 0, 1, 0, 8'h3C, 8'h00);
    #2 pre = 1'b0;
    #1 chk("mid_lo_w1", {7'b0, q1}, 8'h00);
    chk("mid_lo_w8", q8, 8'h00);
    #1 pre = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_edge_w1", {7'b0, q1}, 8'h00);
    chk("mid_edge_w8", q8, 8'h00);

    step("w8_clr", 1, 1, 0, 0, 0, 8'h3C, 8'hC3);
    step("w8_pre", 0, 0, 0, 0, 0, 8'h3C, 8'hC3);
    step("w8_load", 0, 1, 1, 0, 0, 8'h3C, 8'hC3);
    step("w8_idle", 0, 1, 0, 0, 0, 8'h3C, 8'hC3);

    for (int i = 0; i < 60; i++) begin
      step("rand",
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) != 0),
           1'($urandom),
           1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
